// File: rtl/pixel_stream_loader.sv
// rtl/pixel_stream_loader.sv - raster pixel stream to image memory write port loader
//
// Accepts a raster-ordered 1-bit pixel stream (valid/ready), generates x/y
// write addresses, write strobe and data for the image memory, pulses start
// once a complete frame is stored, then holds off input until the filter
// reports fullImageDone (rising edge).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   pixelIn            pixel value of the offered beat
//   pixelValid         source offers a beat
//   frameStart         beat is pixel (0,0) of a frame
//   pixelReady         loader accepts a beat this cycle
//   fullImageDone      filter finished with the stored frame
//   writeMem           image memory write strobe
//   xAddressOut        column address of the write
//   yAddressOut        row address of the write
//   dataOut            pixel written
//   start              one-cycle pulse: frame stored, begin filtering
//   busy               first accepted pixel until fullImageDone edge
//   frameError         one-cycle pulse on frameStart received mid-frame
//   framesLoaded       (PIXEL_LOADER_STATS_EN) start pulse count, wraps
//   beatsDropped       (PIXEL_LOADER_STATS_EN) discarded/abandoned pixels, saturates
//
// Optional feature macro: PIXEL_LOADER_STATS_EN

module pixel_stream_loader #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixelIn,
  input  logic              pixelValid,
  input  logic              frameStart,
  output logic              pixelReady,
  input  logic              fullImageDone,
  output logic              writeMem,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic              dataOut,
  output logic              start,
  output logic              busy,
  output logic              frameError
`ifdef PIXEL_LOADER_STATS_EN
  ,
  output logic [15:0]       framesLoaded,
  output logic [15:0]       beatsDropped
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] xaddr_q, xaddr_d;
  logic [ADDR_W-1:0] yaddr_q, yaddr_d;
  logic              data_q, data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              done_prev_q, done_prev_d;

  logic accept;
  logic x_last;
  logic y_last;
  logic done_rise;

  assign accept    = pixelValid && ready_q;
  assign x_last    = (x_q == ADDR_W'(IMG_WIDTH - 1));
  assign y_last    = (y_q == ADDR_W'(IMG_HEIGHT - 1));
  // Edge against the registered copy so a level still high from the
  // previous frame does not release the loader early.
  assign done_rise = fullImageDone && !done_prev_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    write_d     = 1'b0;
    xaddr_d     = xaddr_q;
    yaddr_d     = yaddr_q;
    data_d      = data_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
    done_prev_d = fullImageDone;

    case (state_q)
      S_IDLE: begin
        // Beats without frameStart are discarded until a frame begins.
        if (accept && frameStart) begin
          write_d = 1'b1;
          xaddr_d = '0;
          yaddr_d = '0;
          data_d  = pixelIn;
          x_d     = ADDR_W'(1);
          y_d     = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          write_d = 1'b1;
          data_d  = pixelIn;
          if (frameStart) begin
            // Resync: abandon the partial frame, this beat becomes (0,0).
            err_d   = 1'b1;
            xaddr_d = '0;
            yaddr_d = '0;
            x_d     = ADDR_W'(1);
            y_d     = '0;
          end else begin
            xaddr_d = x_q;
            yaddr_d = y_q;
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d     = '0;
                state_d = S_KICK;
              end else begin
                y_d = y_q + ADDR_W'(1);
              end
            end else begin
              x_d = x_q + ADDR_W'(1);
            end
          end
        end
      end

      S_KICK: begin
        // One cycle after the final beat, so start lands the cycle after
        // the final write.
        start_d = 1'b1;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (done_rise) begin
          busy_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      write_q     <= 1'b0;
      xaddr_q     <= '0;
      yaddr_q     <= '0;
      data_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      write_q     <= write_d;
      xaddr_q     <= xaddr_d;
      yaddr_q     <= yaddr_d;
      data_q      <= data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign pixelReady  = ready_q;
  assign writeMem    = write_q;
  assign xAddressOut = xaddr_q;
  assign yAddressOut = yaddr_q;
  assign dataOut     = data_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign frameError  = err_q;

`ifdef PIXEL_LOADER_STATS_EN
  logic [15:0] frames_q, frames_d;
  logic [15:0] dropped_q, dropped_d;
  logic [31:0] drop_inc;
  logic [31:0] drop_sum;

  always_comb begin
    frames_d = frames_q + (start_d ? 16'd1 : 16'd0);
    drop_inc = 32'd0;
    if (accept && (state_q == S_IDLE) && !frameStart) begin
      drop_inc = 32'd1;
    end else if (accept && (state_q == S_LOAD) && frameStart) begin
      // Pixels already written in the abandoned frame.
      drop_inc = 32'(y_q) * 32'(IMG_WIDTH) + 32'(x_q);
    end
    drop_sum  = 32'(dropped_q) + drop_inc;
    dropped_d = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q  <= '0;
      dropped_q <= '0;
    end else begin
      frames_q  <= frames_d;
      dropped_q <= dropped_d;
    end
  end

  assign framesLoaded = frames_q;
  assign beatsDropped = dropped_q;
`endif

endmodule

// File: tb/tb_pixel_stream_loader.sv
// tb/tb_pixel_stream_loader.sv - directed self-checking bench for pixel_stream_loader

module tb_pixel_stream_loader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixelIn;
  logic          pixelValid;
  logic          frameStart;
  logic          pixelReady;
  logic          fullImageDone;
  logic          writeMem;
  logic [AW-1:0] xAddressOut;
  logic [AW-1:0] yAddressOut;
  logic          dataOut;
  logic          start;
  logic          busy;
  logic          frameError;
`ifdef PIXEL_LOADER_STATS_EN
  logic [15:0]   framesLoaded;
  logic [15:0]   beatsDropped;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] pat;

  pixel_stream_loader #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixelIn      (pixelIn),
    .pixelValid   (pixelValid),
    .frameStart   (frameStart),
    .pixelReady   (pixelReady),
    .fullImageDone(fullImageDone),
    .writeMem     (writeMem),
    .xAddressOut  (xAddressOut),
    .yAddressOut  (yAddressOut),
    .dataOut      (dataOut),
    .start        (start),
    .busy         (busy),
    .frameError   (frameError)
`ifdef PIXEL_LOADER_STATS_EN
    ,
    .framesLoaded (framesLoaded),
    .beatsDropped (beatsDropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer one beat at a negedge; one cycle later check the resulting write.
  task automatic send_beat(input logic pix, input logic fs, input int ex, input int ey,
                           input logic ew, input logic eerr);
    pixelIn    = pix;
    frameStart = fs;
    pixelValid = 1'b1;
    chk("ready_before_beat", pixelReady, 1);
    @(negedge clk);
    chk("write_strobe", writeMem, ew);
    if (ew) begin
      chk("x_addr", xAddressOut, ex);
      chk("y_addr", yAddressOut, ey);
      chk("data", dataOut, pix);
    end
    chk("frame_error", frameError, eerr);
    chk("start_during_load", start, 0);
  endtask

  task automatic idle(input int n);
    pixelValid = 1'b0;
    frameStart = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("no_write_idle", writeMem, 0);
    end
  endtask

  // Called right after the final beat's write was checked (cycle N+1).
  task automatic finish_frame();
    pixelValid = 1'b0;
    frameStart = 1'b0;
    chk("ready_low_after_last", pixelReady, 0);
    chk("start_n1", start, 0);
    @(negedge clk);
    chk("start_n2", start, 1);
    chk("no_write_n2", writeMem, 0);
    chk("busy_n2", busy, 1);
    @(negedge clk);
    chk("start_n3", start, 0);
    chk("ready_n3", pixelReady, 0);
  endtask

  task automatic send_frame(input logic [11:0] p, input int stall);
    for (int i = 0; i < W * H; i++) begin
      send_beat(p[11-i], (i == 0), i % W, i / W, 1'b1, 1'b0);
      if (i == 0) chk("busy_after_first", busy, 1);
      if (stall > 0 && i < W * H - 1) idle(stall);
    end
    finish_frame();
  endtask

  task automatic release_done();
    fullImageDone = 1'b0;
    @(negedge clk);
    chk("ready_before_done_edge", pixelReady, 0);
    fullImageDone = 1'b1;
    @(negedge clk);
    chk("ready_after_done_edge", pixelReady, 1);
    chk("busy_after_done_edge", busy, 0);
  endtask

  initial begin
    reset         = 1'b1;
    pixelIn       = 1'b0;
    pixelValid    = 1'b0;
    frameStart    = 1'b0;
    fullImageDone = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", pixelReady, 1);
    chk("rst_write", writeMem, 0);
    chk("rst_x", xAddressOut, 0);
    chk("rst_y", yAddressOut, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frameError, 0);
    reset = 1'b0;
    @(negedge clk);

    // IDLE discard: no writes, not busy.
    for (int i = 0; i < 5; i++) begin
      send_beat(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("idle_not_busy", busy, 0);
    end

    // Clean frame with fullImageDone already high.
    pat = 12'b101100111000;
    send_frame(pat, 0);
`ifdef PIXEL_LOADER_STATS_EN
    chk("stats_dropped_5", beatsDropped, 5);
    chk("stats_frames_1", framesLoaded, 1);
`endif

    // Stale high level is ignored; then low, 20 cycles, rising edge.
    pixelValid = 1'b1;
    frameStart = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ready_level_ignored", pixelReady, 0);
    end
    fullImageDone = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("bp_ready", pixelReady, 0);
      chk("bp_busy", busy, 1);
      chk("bp_no_write", writeMem, 0);
    end
    fullImageDone = 1'b1;
    @(negedge clk);
    chk("edge_ready", pixelReady, 1);
    chk("edge_busy", busy, 0);
    chk("edge_beat_not_taken", writeMem, 0);
    pixelValid = 1'b0;
    frameStart = 1'b0;
    @(negedge clk);

    // Stalled frame: 3 idle cycles between beats.
    send_frame(pat, 3);
    release_done();

    // Resync on the 7th beat, then the new frame completes.
    pat = 12'b010011000111;
    for (int i = 0; i < 6; i++) begin
      send_beat(pat[11-i], (i == 0), i % W, i / W, 1'b1, 1'b0);
    end
    send_beat(1'b1, 1'b1, 0, 0, 1'b1, 1'b1);
    for (int i = 1; i < W * H; i++) begin
      send_beat(pat[11-i], 1'b0, i % W, i / W, 1'b1, 1'b0);
    end
    finish_frame();
`ifdef PIXEL_LOADER_STATS_EN
    chk("stats_dropped_11", beatsDropped, 11);
    chk("stats_frames_3", framesLoaded, 3);
`endif
    release_done();

    // Reset in the middle of LOAD after 6 beats.
    for (int i = 0; i < 6; i++) begin
      send_beat(1'b1, (i == 0), i % W, i / W, 1'b1, 1'b0);
    end
    pixelValid = 1'b0;
    frameStart = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", pixelReady, 1);
    chk("mid_rst_write", writeMem, 0);
    chk("mid_rst_x", xAddressOut, 0);
    chk("mid_rst_y", yAddressOut, 0);
    chk("mid_rst_data", dataOut, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frameError, 0);
`ifdef PIXEL_LOADER_STATS_EN
    chk("mid_rst_frames", framesLoaded, 0);
    chk("mid_rst_dropped", beatsDropped, 0);
`endif
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_start", start, 0);
      chk("post_rst_no_write", writeMem, 0);
    end
    pat = 12'b111000110101;
    send_frame(pat, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pixel_stream_loader.md
Name: pixel_stream_loader

Overview:
- Upstream stage of the median filter top.
- Accepts a raster-ordered 1-bit pixel stream through a valid/ready handshake. Generates the x/y write addresses, write strobe and data for the image memory write port.
- Pulses start once a full frame has been stored, then blocks new input until the filter reports fullImageDone.
- Guarantees the filter never reads a half-written frame.

Parameters:
- IMG_WIDTH, 160, pixels per row; legal range 2..256.
- IMG_HEIGHT, 120, rows per frame; legal range 2..256.
- ADDR_W, 8, width of the x and y address outputs.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pixelIn  input  1  pixel value for the current beat
- pixelValid  input  1  source has a beat on pixelIn
- frameStart  input  1  qualifies the current beat as pixel (0,0) of a frame
- pixelReady  output  1  loader accepts a beat this cycle
- fullImageDone  input  1  median stage finished processing the stored frame
- writeMem  output  1  image memory write strobe
- xAddressOut  output  ADDR_W  column address for the write
- yAddressOut  output  ADDR_W  row address for the write
- dataOut  output  1  pixel written to memory
- start  output  1  one-cycle pulse: frame stored, begin filtering
- busy  output  1  high from first accepted pixel until fullImageDone is seen
- frameError  output  1  one-cycle pulse on a frameStart received mid-frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, except pixelReady=1. State IDLE, x=0, y=0.
- Beat acceptance: a beat is accepted when pixelValid && pixelReady at a posedge clk.
- Outputs are registered. For an accepted beat in cycle N, writeMem=1 in cycle N+1, with xAddressOut/yAddressOut/dataOut equal to that beat's coordinates and pixelIn.
- writeMem=0 in any cycle without a beat accepted in the previous cycle. Address and data hold their last values.
- State IDLE: pixelReady=1.
  - Accepted beat with frameStart=0: discarded, no write.
  - Accepted beat with frameStart=1: write (0,0), x=1, go LOAD, busy=1.
- State LOAD: pixelReady=1.
  - Each accepted beat writes at (x,y), then x increments.
  - When x==IMG_WIDTH-1: x wraps to 0 and y increments.
  - Beat at (IMG_WIDTH-1, IMG_HEIGHT-1) accepted in cycle N: go KICK. pixelReady=0 from cycle N+1.
  - Accepted beat with frameStart=1 (other than in IDLE): frameError=1 in cycle N+1, the beat is written at (0,0), x=1, y=0, and the loader stays in LOAD. The partial frame is abandoned and start is not pulsed.
  - pixelValid low: no state change; a stall may last any number of cycles.
- State KICK: start=1 in cycle N+2 for exactly one cycle, i.e. the cycle after the final write. Then go WAIT_DONE.
- State WAIT_DONE: pixelReady=0.
  - Waits for a rising edge of fullImageDone, detected against its value registered one cycle earlier. This ignores a level left high from the previous frame.
  - On the edge: busy=0 and pixelReady=1 on the next cycle; x=0, y=0; go IDLE.
- Counter widths: x and y are ADDR_W wide. The upper bits of the address outputs are zero when the image is smaller than 2^ADDR_W.
- Reset mid-operation: the in-flight frame is abandoned with no start pulse. The next frame must begin with frameStart.
- Simultaneous events: fullImageDone rising in the same cycle as an offered beat in WAIT_DONE. The beat is not accepted, since pixelReady is still 0.

Optional Feature:
- Macro: PIXEL_LOADER_STATS_EN.
- When defined, two extra output ports are added:
  - framesLoaded [15:0]: increments on each start pulse; wraps.
  - beatsDropped [15:0]: increments on each beat discarded in IDLE, and by the number of pixels abandoned on each frameError; saturates at 16'hFFFF.
  - Both clear on reset.
- When not defined, neither port nor its logic exists. All other behaviour is identical.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3):
- Clean frame: 12 back-to-back beats, frameStart on the first, pixel pattern 101100111000.
  - Required: 12 writes at (0,0)..(3,2) with matching data; writeMem one cycle after each acceptance.
  - start pulses exactly once, one cycle after the (3,2) write; pixelReady=0 from then on.
- Backpressure and done: hold fullImageDone=1 from before start, then drop it, then raise it after 20 cycles.
  - Required: pixelReady stays 0 until the cycle after the rising edge; busy falls with it.
- Stalls: same frame as the clean case with pixelValid deasserted for 3 cycles between every beat.
  - Required: identical addresses and data; start arrives 2 cycles after the last accepted beat.
- Resync: frameStart reasserted on the 7th beat of a frame, followed by 12 clean beats.
  - Required: frameError pulses once; writes restart at (0,0); start pulses once after the 12th post-resync beat.
- IDLE discard: 5 beats without frameStart, then a clean frame.
  - Required: no writeMem for the 5 beats; normal frame load follows.
  - With PIXEL_LOADER_STATS_EN: beatsDropped=5, framesLoaded=1.
- Reset mid-LOAD after 6 beats.
  - Required: all outputs return to their reset values; no start pulse; a subsequent clean frame loads normally from (0,0).
